pe_mac_cell: RTL and testbench
==============================

# pe_mac_cell

Processing-element datapath that responds to the training-phase sequencer. It consumes `in_en`, the active-low `pe_rst` clear, and the six phase and stride selects. It performs signed multiply-accumulate for forward pass (FP), backward pass (BP) and weight-gradient (WG) passes, and returns each pass result through a valid/ready port. One instance sits at each array node, downstream of the sequencer and upstream of the result collector.

## Interface
Parameters:
- `DW`, 8: signed operand width.
- `AW`, 20: signed accumulator and result width; requires AW ≥ 2*DW.

Ports:
- `clk`, in, 1: clock.
- `fsm_rst_n`, in, 1: reset, asynchronous, active-low.
- `pe_rst`, in, 1: synchronous pass clear, active-low.
- `in_en`, in, 1: operand-valid strobe from the sequencer.
- `select0`, `select1`, in, 1 each: phase decode.
- `select_m0`, `select_m1`, in, 1 each: stride-2 enable; the effective enable is their AND.
- `select_m2`, in, 1: preload the accumulator from `psum_in` at clear.
- `select_m3`, in, 1: enable the systolic pass-through `act_out`.
- `act_in`, `wgt_in`, `grad_in`, in, DW each: signed operands.
- `psum_in`, in, AW: signed preload value.
- `act_out`, out, DW: `act_in` registered; zero when `select_m3`=0.
- `res_data`, out, AW: pass result.
- `res_valid`, out, 1: result pending.
- `res_ready`, in, 1: result consumer accept.
- `overrun`, out, 1: sticky; an unaccepted result was overwritten.
- `busy`, out, 1: high in ACC or FLUSH.

## Operation
Phase decode, `{select0,select1}`:
- 01, FP: product = act_in*wgt_in.
- 00, BP: product = grad_in*wgt_in.
- 10, WG: product = act_in*grad_in.
- 11, illegal: treated as product 0; accumulation proceeds.

Arithmetic:
- Product is 2*DW signed, sign-extended to AW.
- The accumulator adds per the configuration below.

States:
- IDLE: entered from reset.
  - `pe_rst`=0: acc ← (`select_m2` ? `psum_in` : 0); clear the product pipe and the stride phase; stay IDLE.
  - `in_en`=1 (with `pe_rst`=1): go to ACC; this cycle is an accepted sample.
- ACC: each cycle with `in_en`=1 is a sample.
  - Stride off: every sample is accepted.
  - Stride on: the first sample is accepted, then every other one; the phase toggles per sample.
  - Accepted sample: prod_r ← product, pv ← 1; otherwise pv ← 0.
  - pv=1: acc ← acc + prod_r.
  - `in_en`=0: go to FLUSH.
- FLUSH: add any pending prod_r; at the next edge res_data ← final acc, res_valid ← 1, go to IDLE.
  - If res_valid was already 1 and `res_ready`=0 at that edge: overrun ← 1 and res_data is overwritten.
- Handshake: the result transfers on any edge with res_valid=1 and res_ready=1; res_valid ← 0 unless FLUSH loads a new result on the same edge, in which case res_valid stays 1 and overrun is not set.
- `pe_rst`=0 in ACC or FLUSH: abort the pass and return to IDLE with the clear applied. res_valid and res_data are unaffected. `pe_rst` has priority over `in_en`.
- `in_en` rising while in FLUSH: ignored; the sample is lost and the sequencer must not do this.
- Select changes mid-pass: take effect on the next sample.
- overrun clears only on `fsm_rst_n`.

## Timing
- Reset values: all outputs 0 (`res_data`, `res_valid`, `overrun`, `busy`, `act_out`); state IDLE; acc 0.
- Sample at edge E produces prod_r at E; acc includes it at E+1.
- Last `in_en`=1 at edge E: `in_en`=0 sampled at E+1, entering FLUSH; res_valid rises at E+2.
- Minimum pass-to-pass spacing is 3 cycles.
- `act_out` latency is 1 cycle, independent of phase.
- `busy` is registered and mirrors ACC/FLUSH.

## Configuration
- `PE_SAT_EN` defined: the accumulator add saturates to [-2^(AW-1), 2^(AW-1)-1], and a saturation event holds the value at the clamp.
- `PE_SAT_EN` undefined: two's-complement wrap modulo 2^AW.
- Preload via `psum_in` is never saturated.

## Test plan
- FP, stride off: act=3, wgt=2, 6 `in_en` cycles after `pe_rst` pulse -> res_data=36, res_valid 2 cycles after last sample.
- Stride on (`select_m0`=`select_m1`=1), WG, act=3, grad=2, 6 cycles -> 3 accepted -> res_data=18.
- BP with `select_m2`=1, psum_in=100, grad=-4, wgt=5, 6 cycles -> res_data=-20.
- Saturation, DW=8, AW=20, FP act=-128, wgt=-128, 32 samples:
  - With `PE_SAT_EN` -> res_data=524287.
  - Without `PE_SAT_EN` -> res_data=-524288.
- Overrun: two FP passes with res_ready=0 throughout -> second result in res_data, overrun=1. Then res_ready=1 for 1 cycle -> res_valid=0, overrun stays 1.
- Abort: `pe_rst`=0 after 3 of 6 samples -> state IDLE, busy=0, no res_valid, next full pass gives the clean value 36. `fsm_rst_n` low mid-pass -> all outputs 0 immediately.

Source files
------------

// File: rtl/pe_mac_cell_if.sv
// Result port of the PE MAC cell: valid/ready transfer of one pass result.
// Master drives data/valid, slave (result collector) drives ready.
interface pe_mac_cell_if #(
    parameter int AW = 20
);
    logic [AW-1:0] res_data;
    logic          res_valid;
    logic          res_ready;

    modport master (output res_data, output res_valid, input res_ready);
    modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/pe_mac_cell.sv
// Signed MAC processing element for FP/BP/WG passes with stride-2 decimation and a
// valid/ready result port. Define PE_SAT_EN for a saturating accumulator (default wraps).
module pe_mac_cell #(
    parameter int DW = 8,
    parameter int AW = 20
) (
    input  logic                 clk,
    input  logic                 fsm_rst_n,
    input  logic                 pe_rst,
    input  logic                 in_en,
    input  logic                 select0,
    input  logic                 select1,
    input  logic                 select_m0,
    input  logic                 select_m1,
    input  logic                 select_m2,
    input  logic                 select_m3,
    input  logic signed [DW-1:0] act_in,
    input  logic signed [DW-1:0] wgt_in,
    input  logic signed [DW-1:0] grad_in,
    input  logic signed [AW-1:0] psum_in,
    output logic signed [DW-1:0] act_out,
    output logic                 overrun,
    output logic                 busy,
    pe_mac_cell_if.master        res
);
    localparam int PW = 2 * DW;

    typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_t;

    state_t                 state;
    logic signed [AW-1:0]   acc, prod_r, acc_next, addend, prod_ext;
    logic signed [PW-1:0]   a_x, w_x, g_x, product;
    logic                   pv, phase, stride;

    assign stride = select_m0 & select_m1;
    assign a_x    = PW'(act_in);
    assign w_x    = PW'(wgt_in);
    assign g_x    = PW'(grad_in);

    always_comb begin
        product = '0;
        case ({select0, select1})
            2'b01:   product = a_x * w_x;
            2'b00:   product = g_x * w_x;
            2'b10:   product = a_x * g_x;
            default: product = '0;
        endcase
    end

    assign prod_ext = AW'(product);
    assign addend   = pv ? prod_r : '0;

`ifdef PE_SAT_EN
    logic signed [AW:0] sum;
    always_comb begin
        sum      = {acc[AW-1], acc} + {addend[AW-1], addend};
        acc_next = sum[AW-1:0];
        // Overflow shows as disagreement between the guard bit and the result MSB.
        if (sum[AW] != sum[AW-1])
            acc_next = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
`else
    always_comb begin
        acc_next = acc + addend;
    end
`endif

    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            prod_r        <= '0;
            pv            <= 1'b0;
            phase         <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            act_out       <= '0;
            res.res_data  <= '0;
            res.res_valid <= 1'b0;
        end else begin
            act_out <= select_m3 ? act_in : '0;
            if (res.res_valid && res.res_ready)
                res.res_valid <= 1'b0;

            if (!pe_rst) begin
                state  <= IDLE;
                acc    <= select_m2 ? psum_in : '0;
                prod_r <= '0;
                pv     <= 1'b0;
                phase  <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        acc <= acc_next;
                        pv  <= 1'b0;
                        // First sample of a pass is always taken, whatever the stride phase.
                        if (in_en) begin
                            state  <= ACC;
                            busy   <= 1'b1;
                            prod_r <= prod_ext;
                            pv     <= 1'b1;
                            phase  <= stride;
                        end
                    end
                    ACC: begin
                        acc <= acc_next;
                        if (in_en) begin
                            if (!stride || !phase) begin
                                prod_r <= prod_ext;
                                pv     <= 1'b1;
                            end else begin
                                pv <= 1'b0;
                            end
                            phase <= stride & ~phase;
                        end else begin
                            pv    <= 1'b0;
                            state <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        acc           <= acc_next;
                        pv            <= 1'b0;
                        res.res_data  <= acc_next;
                        res.res_valid <= 1'b1;
                        if (res.res_valid && !res.res_ready)
                            overrun <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pe_mac_cell.sv
// Self-checking bench for pe_mac_cell: directed passes from the test plan plus
// randomized passes against a sample-list reference model.
module tb_pe_mac_cell;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (AW - 1));

    logic                 clk = 1'b0;
    logic                 fsm_rst_n, pe_rst, in_en;
    logic                 select0, select1, select_m0, select_m1, select_m2, select_m3;
    logic signed [DW-1:0] act_in, wgt_in, grad_in, act_out;
    logic signed [AW-1:0] psum_in;
    logic                 overrun, busy;

    pe_mac_cell_if #(.AW(AW)) res_if ();

    pe_mac_cell #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .fsm_rst_n(fsm_rst_n), .pe_rst(pe_rst), .in_en(in_en),
        .select0(select0), .select1(select1), .select_m0(select_m0), .select_m1(select_m1),
        .select_m2(select_m2), .select_m3(select_m3),
        .act_in(act_in), .wgt_in(wgt_in), .grad_in(grad_in), .psum_in(psum_in),
        .act_out(act_out), .overrun(overrun), .busy(busy), .res(res_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sa[64], sg[64], sw[64];

    // Reference: preload, then add each accepted sample's product in order.
    function automatic longint model(input bit [1:0] ph, input bit stride, input bit pre,
                                     input longint psum, input int n);
        longint acc, p, s, span;
        acc  = pre ? psum : 0;
        span = longint'(1) <<< AW;
        for (int i = 0; i < n; i++) begin
            if (stride && (i % 2 == 1)) continue;
            case (ph)
                2'b01:   p = longint'(sa[i]) * sw[i];
                2'b00:   p = longint'(sg[i]) * sw[i];
                2'b10:   p = longint'(sa[i]) * sg[i];
                default: p = 0;
            endcase
            s = acc + p;
`ifdef PE_SAT_EN
            if (s > MAXV) s = MAXV;
            if (s < MINV) s = MINV;
`else
            s = (((s - MINV) % span) + span) % span + MINV;
`endif
            acc = s;
        end
        return acc;
    endfunction

    function automatic int rnd_op();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic fill(input int n, input int a, input int g, input int w);
        for (int i = 0; i < n; i++) begin
            sa[i] = a; sg[i] = g; sw[i] = w;
        end
    endtask

    task automatic do_clear(input bit pre, input longint psum);
        @(negedge clk);
        pe_rst = 1'b0; select_m2 = pre; psum_in = AW'(psum);
        @(negedge clk);
        pe_rst = 1'b1; select_m2 = 1'b0;
    endtask

    task automatic drive_samples(input int n, input bit [1:0] ph, input bit stride);
        select0 = ph[1]; select1 = ph[0];
        select_m0 = stride; select_m1 = stride;
        for (int i = 0; i < n; i++) begin
            act_in = DW'(sa[i]); grad_in = DW'(sg[i]); wgt_in = DW'(sw[i]);
            in_en = 1'b1;
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL busy_after_first_sample: got %b expected 1", busy);
                end
            end
        end
        in_en = 1'b0;
    endtask

    task automatic finish_pass(input longint exp, input bit check_low, input bit ready_at_load,
                               input string nm);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || (check_low && res_if.res_valid !== 1'b0)) begin
            errors++;
            $display("FAIL %s_flush: busy=%b res_valid=%b expected busy=1 res_valid=0", nm, busy,
                     res_if.res_valid);
        end
        res_if.res_ready = ready_at_load;
        @(negedge clk);
        checks++;
        if (res_if.res_valid !== 1'b1 || res_if.res_data !== AW'(exp) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: valid=%b data=%0d busy=%b expected valid=1 data=%0d busy=0",
                     nm, res_if.res_valid, $signed(res_if.res_data), busy, exp);
        end
    endtask

    task automatic accept(input string nm);
        res_if.res_ready = 1'b1;
        @(negedge clk);
        res_if.res_ready = 1'b0;
        checks++;
        if (res_if.res_valid !== 1'b0) begin
            errors++; $display("FAIL %s_accept: res_valid=%b expected 0", nm, res_if.res_valid);
        end
    endtask

    task automatic test_reset();
        fsm_rst_n = 1'b0; pe_rst = 1'b1; in_en = 1'b0;
        select0 = 1'b0; select1 = 1'b0; select_m0 = 1'b0; select_m1 = 1'b0;
        select_m2 = 1'b0; select_m3 = 1'b0;
        act_in = '0; wgt_in = '0; grad_in = '0; psum_in = '0; res_if.res_ready = 1'b0;
        #1;
        checks++;
        if (res_if.res_data !== '0 || res_if.res_valid !== 1'b0 || overrun !== 1'b0 ||
            busy !== 1'b0 || act_out !== '0) begin
            errors++;
            $display("FAIL reset: data=%0d valid=%b overrun=%b busy=%b act_out=%0d expected all 0",
                     res_if.res_data, res_if.res_valid, overrun, busy, act_out);
        end
        @(negedge clk);
        @(negedge clk);
        fsm_rst_n = 1'b1;
    endtask

    task automatic test_fp();
        do_clear(1'b0, 0);
        fill(6, 3, 0, 2);
        drive_samples(6, 2'b01, 1'b0);
        finish_pass(36, 1'b1, 1'b0, "fp");
        accept("fp");
    endtask

    task automatic test_stride();
        do_clear(1'b0, 0);
        fill(6, 3, 2, 0);
        drive_samples(6, 2'b10, 1'b1);
        finish_pass(18, 1'b1, 1'b0, "stride_wg");
        accept("stride_wg");
    endtask

    task automatic test_preload();
        do_clear(1'b1, 100);
        fill(6, 0, -4, 5);
        drive_samples(6, 2'b00, 1'b0);
        finish_pass(-20, 1'b1, 1'b0, "bp_preload");
        accept("bp_preload");
    endtask

    task automatic test_saturation();
        longint exp;
`ifdef PE_SAT_EN
        exp = 524287;
`else
        exp = -524288;
`endif
        do_clear(1'b0, 0);
        fill(32, -128, 0, -128);
        drive_samples(32, 2'b01, 1'b0);
        finish_pass(exp, 1'b1, 1'b0, "saturation");
        accept("saturation");
    endtask

    task automatic test_act_out();
        int v;
        select_m3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = rnd_op();
            act_in = DW'(v);
            @(negedge clk);
            checks++;
            if (act_out !== DW'(v)) begin
                errors++; $display("FAIL act_out_pass: got %0d expected %0d", act_out, v);
            end
        end
        select_m3 = 1'b0; act_in = 8'sd77;
        @(negedge clk);
        checks++;
        if (act_out !== '0) begin
            errors++; $display("FAIL act_out_gated: got %0d expected 0", act_out);
        end
    endtask

    task automatic test_overrun();
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_initial: got %b expected 0", overrun);
        end
        do_clear(1'b0, 0);
        fill(6, 3, 0, 2);
        drive_samples(6, 2'b01, 1'b0);
        finish_pass(36, 1'b1, 1'b0, "overrun_first");
        do_clear(1'b0, 0);
        fill(4, 5, 0, 1);
        drive_samples(4, 2'b01, 1'b0);
        finish_pass(20, 1'b0, 1'b0, "overrun_second");
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        accept("overrun");
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun);
        end
    endtask

    task automatic test_abort();
        do_clear(1'b0, 0);
        fill(6, 3, 0, 2);
        drive_samples(3, 2'b01, 1'b0);
        pe_rst = 1'b0; in_en = 1'b1;
        @(negedge clk);
        pe_rst = 1'b1; in_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_if.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b res_valid=%b expected 0 0", busy, res_if.res_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (res_if.res_valid !== 1'b0) begin
            errors++; $display("FAIL abort_no_result: res_valid=%b expected 0", res_if.res_valid);
        end
        drive_samples(6, 2'b01, 1'b0);
        finish_pass(36, 1'b1, 1'b0, "after_abort");
        accept("after_abort");
    endtask

    task automatic test_async_reset();
        select_m3 = 1'b1;
        do_clear(1'b0, 0);
        fill(6, 3, 0, 2);
        select0 = 1'b0; select1 = 1'b1;
        act_in = 8'sd3; wgt_in = 8'sd2; in_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 fsm_rst_n = 1'b0;
        #1;
        checks++;
        if (res_if.res_data !== '0 || res_if.res_valid !== 1'b0 || overrun !== 1'b0 ||
            busy !== 1'b0 || act_out !== '0) begin
            errors++;
            $display("FAIL async_reset: data=%0d valid=%b overrun=%b busy=%b act_out=%0d expected all 0",
                     res_if.res_data, res_if.res_valid, overrun, busy, act_out);
        end
        in_en = 1'b0; select_m3 = 1'b0;
        @(negedge clk);
        fsm_rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_clear(1'b0, 0);
        fill(2, 3, 0, 2);
        drive_samples(2, 2'b01, 1'b0);
        finish_pass(12, 1'b1, 1'b0, "b2b_first");
        do_clear(1'b0, 0);
        fill(3, 4, 0, -1);
        drive_samples(3, 2'b01, 1'b0);
        finish_pass(-12, 1'b0, 1'b1, "b2b_second");
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL b2b_no_overrun: got %b expected 0", overrun);
        end
        @(negedge clk);
        res_if.res_ready = 1'b0;
        checks++;
        if (res_if.res_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drained: res_valid=%b expected 0", res_if.res_valid);
        end
    endtask

    task automatic test_random();
        bit [1:0] ph;
        bit       stride, pre;
        longint   psum, exp;
        int       n;
        for (int t = 0; t < 20; t++) begin
            ph     = 2'($urandom_range(0, 3));
            stride = 1'($urandom_range(0, 1));
            pre    = 1'($urandom_range(0, 1));
            psum   = longint'($urandom_range(0, (1 << AW) - 1)) + MINV;
            n      = int'($urandom_range(1, 10));
            for (int i = 0; i < n; i++) begin
                sa[i] = rnd_op(); sg[i] = rnd_op(); sw[i] = rnd_op();
            end
            exp = model(ph, stride, pre, psum, n);
            do_clear(pre, psum);
            drive_samples(n, ph, stride);
            finish_pass(exp, 1'b1, 1'b0, $sformatf("random%0d", t));
            accept($sformatf("random%0d", t));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fp();
        test_stride();
        test_preload();
        test_saturation();
        test_act_out();
        test_overrun();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
